// File: rtl/isq_lin_buf.sv
// Issue-queue line buffer: holds renamed instructions in ISQ_DEPTH slots and
// presents one {slot_idx, inst} line per slot to the downstream tpu_lin slots.
// Slots are allocated lowest-free-first and released by the issue stage.
module isq_lin_buf #(
  parameter int INST_WIDTH       = 22,
  parameter int ISQ_IDX_BITS_NUM = 2,
  parameter int ISQ_DEPTH        = 4
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           ins_vld,
  input  logic [INST_WIDTH-1:0]                          ins,
  output logic                                           ins_rdy,
  input  logic                                           iss_vld,
  input  logic [ISQ_IDX_BITS_NUM-1:0]                    iss_idx,
  input  logic                                           flush,
  output logic [ISQ_DEPTH*(INST_WIDTH+ISQ_IDX_BITS_NUM)-1:0] isq_lin_out,
  output logic [ISQ_DEPTH-1:0]                           occ_vec,
  output logic [ISQ_IDX_BITS_NUM:0]                      cnt,
  output logic                                           full,
  output logic                                           empty
);

  localparam int ISQ_LINE_WIDTH = INST_WIDTH + ISQ_IDX_BITS_NUM;
  localparam int CNT_W          = ISQ_IDX_BITS_NUM + 1;

  logic [INST_WIDTH-1:0]       inst_q [ISQ_DEPTH];
  logic [INST_WIDTH-1:0]       inst_d [ISQ_DEPTH];
  logic [ISQ_DEPTH-1:0]        occ_q, occ_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  logic                        accept;
  logic                        iss_hit;
  logic                        free_found;
  logic [ISQ_IDX_BITS_NUM-1:0] alloc_idx;

  // Status flags come straight from registered state; flush blocks intake in the same cycle.
  always_comb begin
    full    = (cnt_q == CNT_W'(ISQ_DEPTH));
    empty   = (cnt_q == '0);
    ins_rdy = ~full & ~flush;
    occ_vec = occ_q;
    cnt     = cnt_q;
  end

  // Lowest-numbered free slot, judged on pre-edge occupancy so a slot being freed is never reused.
  always_comb begin
    free_found = 1'b0;
    alloc_idx  = '0;
    for (int i = 0; i < ISQ_DEPTH; i++) begin
      if (!free_found && !occ_q[i]) begin
        free_found = 1'b1;
        alloc_idx  = ISQ_IDX_BITS_NUM'(i);
      end
    end
  end

  // Next-state: flush wins, otherwise issue release and allocation apply together.
  always_comb begin
    accept  = ins_vld & ins_rdy & ins[INST_WIDTH-1] & free_found;
    iss_hit = iss_vld & occ_q[iss_idx];
    occ_d   = occ_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < ISQ_DEPTH; i++) begin
      inst_d[i] = inst_q[i];
    end
    if (flush) begin
      occ_d = '0;
      cnt_d = '0;
      for (int i = 0; i < ISQ_DEPTH; i++) begin
        inst_d[i] = '0;
      end
    end else begin
      if (iss_hit) begin
        occ_d[iss_idx]  = 1'b0;
        inst_d[iss_idx] = '0;
      end
      if (accept) begin
        occ_d[alloc_idx]  = 1'b1;
        inst_d[alloc_idx] = ins;
      end
      cnt_d = cnt_q + CNT_W'(accept) - CNT_W'(iss_hit);
    end
  end

  // Slot storage and occupancy; reset clears everything so free lines carry an invalid instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < ISQ_DEPTH; i++) begin
        inst_q[i] <= '0;
      end
    end else begin
      occ_q <= occ_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < ISQ_DEPTH; i++) begin
        inst_q[i] <= inst_d[i];
      end
    end
  end

  // Each output line pairs its constant slot index with the registered instruction.
  for (genvar g = 0; g < ISQ_DEPTH; g++) begin : g_line
    assign isq_lin_out[g*ISQ_LINE_WIDTH +: ISQ_LINE_WIDTH] =
      {ISQ_IDX_BITS_NUM'(g), inst_q[g]};
  end

endmodule

// File: tb/tb_isq_lin_buf.sv
// Bench for isq_lin_buf: directed scenarios with literal expectations plus a
// randomized phase checked every cycle against a slot-array reference model.
module tb_isq_lin_buf;

  localparam int IW = 22;
  localparam int XB = 2;
  localparam int D  = 4;
  localparam int LW = IW + XB;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ins_vld = 1'b0;
  logic [IW-1:0]   ins = '0;
  logic            ins_rdy;
  logic            iss_vld = 1'b0;
  logic [XB-1:0]   iss_idx = '0;
  logic            flush = 1'b0;
  logic [D*LW-1:0] isq_lin_out;
  logic [D-1:0]    occ_vec;
  logic [XB:0]     cnt;
  logic            full, empty;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Reference model: one entry per slot
  bit          m_occ  [D];
  logic [IW-1:0] m_inst [D];

  isq_lin_buf #(.INST_WIDTH(IW), .ISQ_IDX_BITS_NUM(XB), .ISQ_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .ins_vld(ins_vld), .ins(ins), .ins_rdy(ins_rdy),
    .iss_vld(iss_vld), .iss_idx(iss_idx), .flush(flush), .isq_lin_out(isq_lin_out),
    .occ_vec(occ_vec), .cnt(cnt), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < D; i++) n += m_occ[i] ? 1 : 0;
    return n;
  endfunction

  function automatic logic [LW-1:0] line(input int i);
    return isq_lin_out[i*LW +: LW];
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model update: queue semantics stated in plain terms
  always @(posedge clk or negedge rst_n) begin
    int n;
    int lo;
    bit acc;
    if (!rst_n || (flush && rst_n)) begin
      for (int i = 0; i < D; i++) begin
        m_occ[i]  <= 1'b0;
        m_inst[i] <= '0;
      end
    end else begin
      n  = m_count();
      lo = -1;
      for (int i = D - 1; i >= 0; i--) if (!m_occ[i]) lo = i;
      acc = ins_vld && (n < D) && ins[IW-1];
      if (iss_vld && m_occ[iss_idx]) begin
        m_occ[iss_idx]  <= 1'b0;
        m_inst[iss_idx] <= '0;
      end
      if (acc && lo >= 0) begin
        m_occ[lo]  <= 1'b1;
        m_inst[lo] <= ins;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      int n;
      logic [D-1:0] eo;
      n = m_count();
      for (int i = 0; i < D; i++) eo[i] = m_occ[i];
      for (int i = 0; i < D; i++) begin
        logic [XB-1:0] ix;
        ix = XB'(i);
        chk($sformatf("cyc_line%0d", i), 128'(line(i)), 128'({ix, m_inst[i]}));
      end
      chk("cyc_occ", 128'(occ_vec), 128'(eo));
      chk("cyc_cnt", 128'(cnt), 128'(n));
      chk("cyc_full", 128'(full), 128'(n == D));
      chk("cyc_empty", 128'(empty), 128'(n == 0));
      chk("cyc_rdy", 128'(ins_rdy), 128'((n < D) && !flush));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit v, input logic [IW-1:0] i, input bit iv,
                     input logic [XB-1:0] ii, input bit f);
    ins_vld = v; ins = i; iss_vld = iv; iss_idx = ii; flush = f;
  endtask

  localparam logic [IW-1:0] I0 = 22'b1_1_0000_1_0010_1_0001_000001;
  localparam logic [IW-1:0] I2 = 22'h2A_5A5A | 22'h20_0000;
  localparam logic [IW-1:0] I3 = 22'h3F_0F01;
  localparam logic [IW-1:0] I4 = 22'h21_2345;
  localparam logic [IW-1:0] I5 = 22'h30_00C3;
  localparam logic [IW-1:0] I6 = 22'h0F_FFFF;

  initial begin
    // Reset values
    tick();
    for (int i = 0; i < D; i++) chk($sformatf("rst_line%0d", i), 128'(line(i)), 128'(i) << IW);
    chk("rst_cnt", 128'(cnt), 128'(0));
    chk("rst_empty", 128'(empty), 128'(1));
    chk("rst_full", 128'(full), 128'(0));
    chk("rst_rdy", 128'(ins_rdy), 128'(1));
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Two accepts of the reference instruction
    drv(1, I0, 0, 0, 0); tick(); tick();
    drv(0, '0, 0, 0, 0);
    chk("acc_line0", 128'(line(0)), 128'(24'h309441));
    chk("acc_line1", 128'(line(1)), 128'(24'h709441));
    chk("acc_cnt", 128'(cnt), 128'(2));
    chk("acc_occ", 128'(occ_vec), 128'(4'b0011));

    // Fill, stall while full, free slot 2, stalled inst lands there
    drv(1, I2, 0, 0, 0); tick();
    drv(1, I3, 0, 0, 0); tick();
    chk("fill_full", 128'(full), 128'(1));
    chk("fill_rdy", 128'(ins_rdy), 128'(0));
    drv(1, I4, 0, 0, 0); tick();
    chk("stall_line3", 128'(line(3)), 128'({2'd3, I3}));
    chk("stall_cnt", 128'(cnt), 128'(4));
    drv(1, I4, 1, 2, 0); tick();
    chk("iss2_line2", 128'(line(2)), 128'({2'd2, 22'd0}));
    chk("iss2_cnt", 128'(cnt), 128'(3));
    tick();
    drv(0, '0, 0, 0, 0);
    chk("reuse_line2", 128'(line(2)), 128'({2'd2, I4}));
    chk("reuse_cnt", 128'(cnt), 128'(4));

    // Concurrent accept and issue: new inst to slot 3, slot 0 freed
    drv(0, '0, 1, 3, 0); tick();
    drv(1, I5, 1, 0, 0); tick();
    chk("both_line3", 128'(line(3)), 128'({2'd3, I5}));
    chk("both_line0", 128'(line(0)), 128'({2'd0, 22'd0}));
    chk("both_cnt", 128'(cnt), 128'(3));
    drv(0, '0, 1, 0, 0); tick();
    chk("iss_free_cnt", 128'(cnt), 128'(3));
    chk("iss_free_occ", 128'(occ_vec), 128'(4'b1110));

    // Offer with vld bit clear is dropped
    drv(1, I6, 0, 0, 0); tick();
    chk("novld_cnt", 128'(cnt), 128'(3));
    chk("novld_line0", 128'(line(0)), 128'({2'd0, 22'd0}));

    // Flush overrides concurrent accept and issue
    drv(1, I0, 1, 1, 1); tick();
    drv(0, '0, 0, 0, 0);
    chk("flush_cnt", 128'(cnt), 128'(0));
    chk("flush_occ", 128'(occ_vec), 128'(0));
    for (int i = 0; i < D; i++) chk($sformatf("flush_line%0d", i), 128'(line(i)), 128'(i) << IW);

    // Asynchronous reset between edges
    drv(1, I3, 0, 0, 0); tick(); tick();
    drv(0, '0, 0, 0, 0);
    chk("pre_arst_cnt", 128'(cnt), 128'(2));
    rst_n = 1'b0; #1;
    chk("arst_cnt", 128'(cnt), 128'(0));
    chk("arst_line0", 128'(line(0)), 128'(0));
    chk("arst_empty", 128'(empty), 128'(1));
    rst_n = 1'b1;

    // Randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      logic [IW-1:0] r;
      r = IW'($urandom);
      if ($urandom_range(0, 3) != 0) r[IW-1] = 1'b1;
      drv($urandom_range(0, 9) < 6, r, $urandom_range(0, 9) < 4,
          XB'($urandom_range(0, D - 1)), $urandom_range(0, 99) < 3);
      tick();
    end
    drv(0, '0, 0, 0, 0);
    tick();
    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
